// File: rtl/sram_arbiter_ctrl_if.sv
// sram_arbiter_ctrl_if: request and read-return bus between client ports and the SRAM arbiter.
// SRAM_ARB_BYTE_MASK_EN adds per-port byte enables (REQ_BE).
interface sram_arbiter_ctrl_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]        REQ_VALID;
  logic [NUM_PORTS-1:0]        REQ_READY;
  logic [NUM_PORTS-1:0]        REQ_WE;
  logic [NUM_PORTS*ADDR_W-1:0] REQ_ADDR;
  logic [NUM_PORTS*DATA_W-1:0] REQ_WDATA;
  logic [NUM_PORTS-1:0]        RD_VALID;
  logic [DATA_W-1:0]           RD_DATA;
`ifdef SRAM_ARB_BYTE_MASK_EN
  logic [NUM_PORTS*2-1:0]      REQ_BE;
  modport master (output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BE, input REQ_READY, RD_VALID, RD_DATA);
  modport slave  (input REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BE, output REQ_READY, RD_VALID, RD_DATA);
`else
  modport master (output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, input REQ_READY, RD_VALID, RD_DATA);
  modport slave  (input REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, output REQ_READY, RD_VALID, RD_DATA);
`endif
endinterface

// File: rtl/sram_arbiter_ctrl.sv
// sram_arbiter_ctrl: per-port request FIFOs, round-robin arbiter and async-SRAM pin sequencer.
// SRAM_ARB_BYTE_MASK_EN enables per-request byte lanes on SRAM_UB_N/SRAM_LB_N.
module sram_arbiter_ctrl #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              SRAM_CLK,
  input  logic              SRAM_RST_N,
  sram_arbiter_ctrl_if.slave bus,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(NUM_PORTS);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, TURN = 2'd3;
  logic [1:0] state, nxt;
  logic              f_we   [NUM_PORTS][FIFO_DEPTH];
  logic [ADDR_W-1:0] f_addr [NUM_PORTS][FIFO_DEPTH];
  logic [DATA_W-1:0] f_data [NUM_PORTS][FIFO_DEPTH];
  logic [PW-1:0] wp [NUM_PORTS];
  logic [PW-1:0] rp [NUM_PORTS];
  logic [PW:0]   cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] push, pop, nonempty;
  logic [GW-1:0] last, gnt, rd_port;
  logic found, go;
  logic [DATA_W-1:0] wdata_q;
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      nonempty[p] = cnt[p] != '0;
      bus.REQ_READY[p] = cnt[p] != FULL;
      push[p] = bus.REQ_VALID[p] && cnt[p] != FULL;
    end
  end
  // Round-robin: first non-empty FIFO after the last granted port.
  always_comb begin
    found = 1'b0;
    gnt = last;
    for (int i = 1; i <= NUM_PORTS; i++)
      if (!found && nonempty[(int'(last) + i) % NUM_PORTS]) begin
        found = 1'b1;
        gnt = GW'((int'(last) + i) % NUM_PORTS);
      end
    nxt = !found ? IDLE : !f_we[gnt][rp[gnt]] ? RD : state == RD ? TURN : WR;
    go = nxt == RD || nxt == WR;
    pop = go ? NUM_PORTS'(1) << gnt : '0;
  end
  always_ff @(posedge SRAM_CLK or negedge SRAM_RST_N)
    if (!SRAM_RST_N) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wp[p] <= '0;
        rp[p] <= '0;
        cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wp[p] <= wp[p] + PW'(push[p]);
        rp[p] <= rp[p] + PW'(pop[p]);
        cnt[p] <= cnt[p] + (PW+1)'(push[p]) - (PW+1)'(pop[p]);
      end
    end
  always_ff @(posedge SRAM_CLK)
    for (int p = 0; p < NUM_PORTS; p++)
      if (push[p]) begin
        f_we[p][wp[p]] <= bus.REQ_WE[p];
        f_addr[p][wp[p]] <= bus.REQ_ADDR[p*ADDR_W +: ADDR_W];
        f_data[p][wp[p]] <= bus.REQ_WDATA[p*DATA_W +: DATA_W];
      end
  // Pin controls are registered from the next state so they are clean for the whole op cycle.
  always_ff @(posedge SRAM_CLK or negedge SRAM_RST_N)
    if (!SRAM_RST_N) begin
      state <= IDLE;
      last <= GW'(NUM_PORTS - 1);
      rd_port <= '0;
      SRAM_ADDR <= '0;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      wdata_q <= '0;
      bus.RD_VALID <= '0;
      bus.RD_DATA <= '0;
    end else begin
      state <= nxt;
      SRAM_OE_N <= nxt != RD;
      SRAM_WE_N <= nxt != WR;
      bus.RD_VALID <= state == RD ? NUM_PORTS'(1) << rd_port : '0;
      if (state == RD) bus.RD_DATA <= SRAM_DQ;
      if (go) begin
        last <= gnt;
        rd_port <= gnt;
        SRAM_ADDR <= f_addr[gnt][rp[gnt]];
        wdata_q <= f_data[gnt][rp[gnt]];
      end
    end
  assign SRAM_DQ = state == WR ? wdata_q : 'z;
  assign SRAM_CE_N = 1'b0;
`ifdef SRAM_ARB_BYTE_MASK_EN
  logic [1:0] f_be [NUM_PORTS][FIFO_DEPTH];
  always_ff @(posedge SRAM_CLK)
    for (int p = 0; p < NUM_PORTS; p++)
      if (push[p]) f_be[p][wp[p]] <= bus.REQ_BE[2*p +: 2];
  always_ff @(posedge SRAM_CLK or negedge SRAM_RST_N)
    if (!SRAM_RST_N) {SRAM_UB_N, SRAM_LB_N} <= 2'b11;
    else {SRAM_UB_N, SRAM_LB_N} <= go ? ~f_be[gnt][rp[gnt]] : 2'b11;
`else
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
`endif
endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// tb_sram_arbiter_ctrl: directed checks of arbitration, SRAM pin sequencing, FIFO full and reset.
// Also covers the SRAM_ARB_BYTE_MASK_EN build when that macro is defined.
module tb_sram_arbiter_ctrl;
  localparam int NP = 4, AW = 20, DW = 16, FD = 4;
`ifdef SRAM_ARB_BYTE_MASK_EN
  localparam logic [1:0] RST_UBLB = 2'b11, MASK_UBLB = 2'b10;
`else
  localparam logic [1:0] RST_UBLB = 2'b00, MASK_UBLB = 2'b00;
`endif
  logic SRAM_CLK = 1'b0;
  logic SRAM_RST_N = 1'b0;
  always #5 SRAM_CLK = ~SRAM_CLK;
  sram_arbiter_ctrl_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic ce_n, oe_n, we_n, ub_n, lb_n;
  sram_arbiter_ctrl #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .SRAM_CLK(SRAM_CLK), .SRAM_RST_N(SRAM_RST_N), .bus(bus),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n));
  // SRAM model: unwritten locations read back as {8'hC3, addr[7:0]}.
  logic [DW-1:0] mem [256];
  logic [255:0] wr_ok = '0;
  assign sram_dq = (!oe_n && we_n) ? (wr_ok[sram_addr[7:0]] ? mem[sram_addr[7:0]] : {8'hC3, sram_addr[7:0]}) : 'z;
  always @(posedge SRAM_CLK)
    if (!we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0] <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
      wr_ok[sram_addr[7:0]] <= 1'b1;
    end
  logic cnt_en = 1'b0;
  int p0_ops = 0;
  always @(negedge SRAM_CLK)
    if (cnt_en && !we_n && sram_addr >= 20'h40 && sram_addr <= 20'h44) p0_ops <= p0_ops + 1;
  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] zz = 'z;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge SRAM_CLK);
  endtask
  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.REQ_VALID[p] = 1'b1;
    bus.REQ_WE[p] = we;
    bus.REQ_ADDR[p*AW +: AW] = a;
    bus.REQ_WDATA[p*DW +: DW] = d;
  endtask
  initial begin
    bus.REQ_VALID = '0;
    bus.REQ_WE = '0;
    bus.REQ_ADDR = '0;
    bus.REQ_WDATA = '0;
`ifdef SRAM_ARB_BYTE_MASK_EN
    bus.REQ_BE = '1;
`endif
    repeat (2) tick();
    chk("rst_oe_n", oe_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rd_valid", bus.RD_VALID, 0);
    chk("rst_rd_data", bus.RD_DATA, 0);
    chk("rst_dq_z", sram_dq, zz);
    chk("ce_n", ce_n, 0);
    chk("rst_ublb", {ub_n, lb_n}, RST_UBLB);
    SRAM_RST_N = 1'b1;
    tick();
    chk("rst_ready", bus.REQ_READY, 4'hF);
    // write then read back on port 0
    set_req(0, 1'b1, 20'h10, 16'hBEEF);
    tick();
    bus.REQ_VALID = '0;
    tick();
    chk("wr_we_n", we_n, 0);
    chk("wr_oe_n", oe_n, 1);
    chk("wr_addr", sram_addr, 20'h10);
    chk("wr_dq", sram_dq, 16'hBEEF);
    chk("wr_ublb", {ub_n, lb_n}, 2'b00);
    tick();
    chk("idle_we_n", we_n, 1);
    chk("idle_dq_z", sram_dq, zz);
    set_req(0, 1'b0, 20'h10, 16'h0);
    tick();
    bus.REQ_VALID = '0;
    tick();
    chk("rd_oe_n", oe_n, 0);
    chk("rd_addr", sram_addr, 20'h10);
    chk("rd_early_valid", bus.RD_VALID, 0);
    tick();
    chk("rd_valid", bus.RD_VALID, 4'b0001);
    chk("rd_data", bus.RD_DATA, 16'hBEEF);
    chk("rd_oe_n_off", oe_n, 1);
    tick();
    chk("rd_valid_pulse", bus.RD_VALID, 0);
    // byte-masked write
    set_req(0, 1'b1, 20'h11, 16'hAAAA);
`ifdef SRAM_ARB_BYTE_MASK_EN
    bus.REQ_BE[1:0] = 2'b01;
`endif
    tick();
    bus.REQ_VALID = '0;
    tick();
    chk("mask_we_n", we_n, 0);
    chk("mask_ublb", {ub_n, lb_n}, MASK_UBLB);
    tick();
    chk("mask_idle_ublb", {ub_n, lb_n}, RST_UBLB);
`ifdef SRAM_ARB_BYTE_MASK_EN
    bus.REQ_BE = '1;
`endif
    // reset asserted mid-read
    set_req(1, 1'b0, 20'h51, 16'h0);
    set_req(2, 1'b0, 20'h52, 16'h0);
    set_req(3, 1'b0, 20'h53, 16'h0);
    tick();
    bus.REQ_VALID = '0;
    tick();
    chk("pre_rst_oe_n", oe_n, 0);
    chk("pre_rst_addr", sram_addr, 20'h51);
    SRAM_RST_N = 1'b0;
    #1;
    chk("async_oe_n", oe_n, 1);
    tick();
    chk("rst_mid_valid", bus.RD_VALID, 0);
    SRAM_RST_N = 1'b1;
    chk("rst_mid_ready", bus.REQ_READY, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", bus.RD_VALID, 0);
      chk("post_rst_oe_n", oe_n, 1);
    end
    // four contending reads: grants 0,1,2,3 back to back
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 20'h20 + AW'(p), 16'h0);
    tick();
    bus.REQ_VALID = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) begin
        chk("rr_oe_n", oe_n, 0);
        chk("rr_addr", sram_addr, 20'h20 + i);
      end
      if (i > 0) begin
        chk("rr_valid", bus.RD_VALID, 32'(1) << (i - 1));
        chk("rr_data", bus.RD_DATA, {8'hC3, 8'h20 + 8'(i - 1)});
      end
    end
    // read then write: RD, TURN, WR
    set_req(1, 1'b0, 20'h30, 16'h0);
    set_req(2, 1'b1, 20'h31, 16'h1234);
    tick();
    bus.REQ_VALID = '0;
    tick();
    chk("rt_rd_oe_n", oe_n, 0);
    chk("rt_rd_we_n", we_n, 1);
    chk("rt_rd_dq", sram_dq, 16'hC330);
    tick();
    chk("turn_oe_n", oe_n, 1);
    chk("turn_we_n", we_n, 1);
    chk("turn_dq_z", sram_dq, zz);
    chk("turn_rd_valid", bus.RD_VALID, 4'b0010);
    chk("turn_rd_data", bus.RD_DATA, 16'hC330);
    tick();
    chk("tw_we_n", we_n, 0);
    chk("tw_addr", sram_addr, 20'h31);
    chk("tw_dq", sram_dq, 16'h1234);
    tick();
    chk("tw_mem", mem[8'h31], 16'h1234);
    // port 0 gets last grant, then overfills its FIFO while others win arbitration
    set_req(0, 1'b1, 20'h3F, 16'h0F0F);
    tick();
    bus.REQ_VALID = '0;
    repeat (2) tick();
    cnt_en = 1'b1;
    for (int p = 1; p < NP; p++) set_req(p, 1'b1, 20'h60 + AW'(p), 16'h6000);
    for (int i = 0; i < FD + 1; i++) begin
      set_req(0, 1'b1, 20'h40 + AW'(i), 16'hD000 + DW'(i));
      if (i == FD) chk("full_ready", bus.REQ_READY, 4'hE);
      tick();
      bus.REQ_VALID[NP-1:1] = '0;
    end
    bus.REQ_VALID = '0;
    repeat (10) tick();
    chk("full_ops", p0_ops, FD);
    chk("full_drop", wr_ok[8'h44], 0);
    chk("full_last", mem[8'h43], 16'hD003);
    chk("full_ready_after", bus.REQ_READY, 4'hF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_arbiter_ctrl.md
SRAM_ARBITER_CTRL -- requirements
Module: sram_arbiter_ctrl

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of request ports (2..8).
REQ-002 Parameter ADDR_W, default 20, SRAM address width.
REQ-003 Parameter DATA_W, default 16, SRAM data width.
REQ-004 Parameter FIFO_DEPTH, default 4, per-port request FIFO entries (power of 2, >=2).
REQ-005 SRAM_CLK  in  1  single clock for all logic; one clock, no clock-domain crossing.
REQ-006 SRAM_RST_N  in  1  asynchronous, active-low reset.
REQ-007 REQ_VALID  in  NUM_PORTS  per-port request valid.
REQ-008 REQ_READY  out  NUM_PORTS  per-port FIFO not full.
REQ-009 REQ_WE  in  NUM_PORTS  1 = write, 0 = read.
REQ-010 REQ_ADDR  in  NUM_PORTS*ADDR_W  per-port address; port p at bits [p*ADDR_W +: ADDR_W].
REQ-011 REQ_WDATA  in  NUM_PORTS*DATA_W  per-port write data.
REQ-012 RD_VALID  out  NUM_PORTS  one-cycle pulse per completed read.
REQ-013 RD_DATA  out  DATA_W  read data, shared by all ports, qualified by RD_VALID.
REQ-014 SRAM_ADDR  out  ADDR_W; SRAM_DQ  inout  DATA_W; SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each.

Function
REQ-015 Request accepted at a rising edge when REQ_VALID[p] && REQ_READY[p]; {WE, ADDR, WDATA} pushed into FIFO p; REQ_VALID while REQ_READY=0 is ignored.
REQ-016 REQ_READY[p] = FIFO p not full at cycle start; a same-cycle pop does not make a full FIFO accept.
REQ-017 A pushed entry becomes visible to the arbiter in the cycle after the push edge.
REQ-018 Arbiter: round-robin, searching from last-granted+1 modulo NUM_PORTS over non-empty FIFOs; one grant per cycle at most.
REQ-019 FSM states IDLE, RD, WR, TURN; state = operation driven on SRAM pins this cycle; SRAM_ADDR, SRAM_OE_N, SRAM_WE_N registered.
REQ-020 Next state: no non-empty FIFO -> IDLE; winner head is read -> RD; head is write and current state RD -> TURN (no pop, pointer unchanged); otherwise head is write -> WR.
REQ-021 Entering RD/WR pops winner FIFO, loads SRAM_ADDR, records winner as last-granted.
REQ-022 RD: OE_N=0, WE_N=1, DQ tri-stated; DQ sampled at the edge ending RD, RD_DATA updated, RD_VALID[winner]=1 for exactly the following cycle.
REQ-023 WR: OE_N=1, WE_N=0 for the full cycle, DQ driven with entry write data; DQ driven only in WR.
REQ-024 IDLE/TURN: OE_N=1, WE_N=1, DQ tri-stated, SRAM_ADDR holds.
REQ-025 Read-after-write and back-to-back same-type ops insert no gap; sustained throughput is one op per cycle except TURN.
REQ-026 Uncontended read accepted at edge k: launched at edge k+1, RD_VALID high between edges k+2 and k+3.
REQ-027 Per-port ordering preserved; cross-port ordering is arbitration order only.
REQ-028 SRAM_CE_N tied 0.

Reset
REQ-029 SRAM_RST_N low immediately: all FIFOs empty, REQ_READY all 1 after release, RD_VALID=0, RD_DATA=0, SRAM_ADDR=0, OE_N=1, WE_N=1, DQ tri-stated, state IDLE, last-granted=NUM_PORTS-1 (port 0 wins first).
REQ-030 Reset mid-operation aborts the op; pending/in-flight reads never produce RD_VALID.

Configuration
REQ-031 Macro SRAM_ARB_BYTE_MASK_EN defined: input REQ_BE (NUM_PORTS*2) exists, is stored per entry, and drives SRAM_UB_N=~BE[1], SRAM_LB_N=~BE[0] during RD/WR (1 otherwise, and after reset); requires DATA_W=16.
REQ-032 Macro undefined: REQ_BE absent; SRAM_UB_N=SRAM_LB_N=0 constantly.

Verification
REQ-033 Single read port 0 addr 0x00010 after write 0x00010=0xBEEF -> RD_VALID[0] pulse with RD_DATA=0xBEEF two edges after read acceptance.
REQ-034 Ports 0..3 each hold one read from cycle 0 -> grants in order 0,1,2,3, four consecutive RD cycles, no idle.
REQ-035 Port 1 read then port 2 write 0x1234 queued -> RD, TURN, WR sequence; DQ never driven during RD or TURN.
REQ-036 Port 0 pushes FIFO_DEPTH+1 requests with no drain stall possible -> REQ_READY[0]=0 at full, extra request dropped, exactly FIFO_DEPTH ops issued.
REQ-037 Assert SRAM_RST_N low during RD -> OE_N=1 immediately, no RD_VALID, all FIFOs empty after release, next grant to port 0.
REQ-038 With SRAM_ARB_BYTE_MASK_EN, write BE=2'b01 data 0xAAAA -> UB_N=1, LB_N=0 during WR; without macro UB_N=LB_N=0 throughout.
